mips32_pipe_fwd: RTL and testbench

- Single-clock, 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset integer pipeline; next generation of the two-phase core.
- Adds parametrised data width, operand forwarding with a selectable mode, load-use interlock, branch resolution in EX with flush, and external instruction/data memory ports.
- Sits between the instruction ROM, the data RAM and the debug/test harness.

---
 rtl/mips32_pipe_fwd.sv | 232 +++++++++++++++++++++++
 tb/tb_mips32_pipe_fwd.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_pipe_fwd.sv
// 5-stage MIPS32-subset pipeline: EX-stage branches with 2-slot flush, forwarding or interlock hazard mode, sticky HLT freeze.
// Fetch-to-retire latency 4 cycles; hazards hold PC and IF/ID and inject a bubble into EX.
module mips32_pipe_fwd #(
  parameter int XLEN     = 32,
  parameter int AW       = 10,
  parameter int RESET_PC = 0,
  parameter int FWD_EN   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [AW-1:0]   imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            illegal,
  output logic            retire,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
  localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;
  localparam bit FWD = (FWD_EN != 0);

  logic [AW-1:0]   pc;
  logic            fetch_stop;
  logic            ifid_vld;
  logic [31:0]     ifid_ir;
  logic [AW-1:0]   ifid_npc;
  logic            idex_vld, idex_wr, idex_halt, idex_ill;
  logic [5:0]      idex_op;
  logic [4:0]      idex_rs, idex_rt, idex_dst;
  logic [XLEN-1:0] idex_a, idex_b, idex_imm;
  logic [AW-1:0]   idex_npc;
  logic            exmem_vld, exmem_wr, exmem_halt, exmem_ill;
  logic [5:0]      exmem_op;
  logic [4:0]      exmem_dst;
  logic [XLEN-1:0] exmem_alu, exmem_b;
  logic            memwb_vld, memwb_wr, memwb_halt, memwb_ill;
  logic [4:0]      memwb_dst;
  logic [XLEN-1:0] memwb_val;
  logic [XLEN-1:0] regs [32];

  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_rd, id_dst;
  logic            id_use_rs, id_use_rt, id_wr, id_wr_nz, id_halt_op, id_ill, id_halt;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  logic            wb_we, dep_ex, dep_mem, hazard, exmem_fwd;
  logic [XLEN-1:0] ex_a, ex_b, ex_res;
  logic            ex_taken;
  logic [AW-1:0]   ex_target;

  assign id_op  = ifid_ir[31:26];
  assign id_rs  = ifid_ir[25:21];
  assign id_rt  = ifid_ir[20:16];
  assign id_rd  = ifid_ir[15:11];
  assign id_imm = {{(XLEN-16){ifid_ir[15]}}, ifid_ir[15:0]};

  always_comb begin
    id_use_rs  = 1'b0;
    id_use_rt  = 1'b0;
    id_wr      = 1'b0;
    id_dst     = id_rt;
    id_halt_op = 1'b0;
    id_ill     = 1'b0;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
        id_wr     = 1'b1;
        id_dst    = id_rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        id_use_rs = 1'b1;
        id_wr     = 1'b1;
      end
      OP_SW: begin
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: id_use_rs = 1'b1;
      OP_HLT:            id_halt_op = 1'b1;
      default: begin
        id_halt_op = 1'b1;
        id_ill     = 1'b1;
      end
    endcase
  end

  assign id_wr_nz = id_wr && (id_dst != 5'd0);
  assign id_halt  = ifid_vld && id_halt_op;

  // Register file reads see the value being written back this cycle.
  assign wb_we = memwb_vld && memwb_wr;
  assign id_a  = (id_rs == 5'd0) ? '0 : (wb_we && memwb_dst == id_rs) ? memwb_val : regs[id_rs];
  assign id_b  = (id_rt == 5'd0) ? '0 : (wb_we && memwb_dst == id_rt) ? memwb_val : regs[id_rt];

  assign dep_ex  = idex_vld && idex_wr &&
                   ((id_use_rs && idex_dst == id_rs) || (id_use_rt && idex_dst == id_rt));
  assign dep_mem = exmem_vld && exmem_wr &&
                   ((id_use_rs && exmem_dst == id_rs) || (id_use_rt && exmem_dst == id_rt));
  assign hazard  = ifid_vld && (FWD ? (dep_ex && idex_op == OP_LW) : (dep_ex || dep_mem));

  // A load's EX/MEM value is an address, never a result; load-use stalls keep it out of reach anyway.
  assign exmem_fwd = FWD && exmem_vld && exmem_wr && (exmem_op != OP_LW);
  assign ex_a = (exmem_fwd && exmem_dst == idex_rs) ? exmem_alu :
                (FWD && wb_we && memwb_dst == idex_rs) ? memwb_val : idex_a;
  assign ex_b = (exmem_fwd && exmem_dst == idex_rt) ? exmem_alu :
                (FWD && wb_we && memwb_dst == idex_rt) ? memwb_val : idex_b;

  always_comb begin
    ex_res = '0;
    case (idex_op)
      OP_ADD:               ex_res = ex_a + ex_b;
      OP_SUB:               ex_res = ex_a - ex_b;
      OP_AND:               ex_res = ex_a & ex_b;
      OP_OR:                ex_res = ex_a | ex_b;
      OP_SLT:               ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      OP_MUL:               ex_res = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + idex_imm;
      OP_SUBI:              ex_res = ex_a - idex_imm;
      OP_SLTI:              ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(idex_imm))};
      default:              ex_res = '0;
    endcase
  end

  assign ex_taken  = idex_vld && ((idex_op == OP_BEQZ && ex_a == '0) ||
                                  (idex_op == OP_BNEQZ && ex_a != '0));
  assign ex_target = idex_npc + idex_imm[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= AW'(RESET_PC);
      fetch_stop <= 1'b0;
      ifid_vld   <= 1'b0;
      ifid_ir    <= '0;
      ifid_npc   <= '0;
      idex_vld   <= 1'b0;
      idex_wr    <= 1'b0;
      idex_halt  <= 1'b0;
      idex_ill   <= 1'b0;
      idex_op    <= '0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_dst   <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_npc   <= '0;
      exmem_vld  <= 1'b0;
      exmem_wr   <= 1'b0;
      exmem_halt <= 1'b0;
      exmem_ill  <= 1'b0;
      exmem_op   <= '0;
      exmem_dst  <= '0;
      exmem_alu  <= '0;
      exmem_b    <= '0;
      memwb_vld  <= 1'b0;
      memwb_wr   <= 1'b0;
      memwb_halt <= 1'b0;
      memwb_ill  <= 1'b0;
      memwb_dst  <= '0;
      memwb_val  <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted) begin
      // Flush beats stall; a halt in ID keeps PC and feeds bubbles from then on.
      if (ex_taken) begin
        pc       <= ex_target;
        ifid_vld <= 1'b0;
      end else if (hazard) begin
        pc       <= pc;
      end else if (id_halt || fetch_stop) begin
        fetch_stop <= 1'b1;
        ifid_vld   <= 1'b0;
      end else begin
        ifid_vld <= 1'b1;
        ifid_ir  <= imem_rdata;
        ifid_npc <= pc + AW'(1);
        pc       <= pc + AW'(1);
      end

      idex_vld  <= ifid_vld && !ex_taken && !hazard;
      idex_wr   <= id_wr_nz;
      idex_halt <= id_halt_op;
      idex_ill  <= id_ill;
      idex_op   <= id_op;
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_dst  <= id_dst;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= id_imm;
      idex_npc  <= ifid_npc;

      exmem_vld  <= idex_vld;
      exmem_wr   <= idex_wr;
      exmem_halt <= idex_halt;
      exmem_ill  <= idex_ill;
      exmem_op   <= idex_op;
      exmem_dst  <= idex_dst;
      exmem_alu  <= ex_res;
      exmem_b    <= ex_b;

      memwb_vld  <= exmem_vld;
      memwb_wr   <= exmem_wr;
      memwb_halt <= exmem_halt;
      memwb_ill  <= exmem_ill;
      memwb_dst  <= exmem_dst;
      memwb_val  <= (exmem_op == OP_LW) ? dmem_rdata : exmem_alu;

      if (wb_we) regs[memwb_dst] <= memwb_val;
      if (memwb_vld && memwb_halt) begin
        halted  <= 1'b1;
        illegal <= memwb_ill;
      end
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = exmem_alu[AW-1:0];
  assign dmem_wdata = exmem_b;
  assign dmem_we    = exmem_vld && (exmem_op == OP_SW) && !halted;
  assign retire     = memwb_vld && !halted;
  assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// Runs directed and random programs on a forwarding core and an interlock-only core against an ISA-level model.
module tb_mips32_pipe_fwd;
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
  localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
  localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63, BAD = 6'b010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [31:0] imem [0:1023];
  logic [31:0] init_mem [0:1023];
  logic [31:0] dmem_f [0:1023];
  logic [31:0] dmem_i [0:1023];

  logic [9:0]  imem_addr_f, imem_addr_i, dmem_addr_f, dmem_addr_i;
  logic [31:0] imem_rdata_f, imem_rdata_i, dmem_rdata_f, dmem_rdata_i;
  logic [31:0] dmem_wdata_f, dmem_wdata_i, dbg_rdata_f, dbg_rdata_i;
  logic        dmem_we_f, dmem_we_i, halted_f, halted_i, illegal_f, illegal_i, retire_f, retire_i;
  logic [4:0]  dbg_f = 5'd0, dbg_i = 5'd0;

  assign imem_rdata_f = imem[imem_addr_f];
  assign imem_rdata_i = imem[imem_addr_i];
  assign dmem_rdata_f = dmem_f[dmem_addr_f];
  assign dmem_rdata_i = dmem_i[dmem_addr_i];

  always @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < 1024; k++) dmem_f[k] <= init_mem[k];
    else if (dmem_we_f) dmem_f[dmem_addr_f] <= dmem_wdata_f;
  end
  always @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < 1024; k++) dmem_i[k] <= init_mem[k];
    else if (dmem_we_i) dmem_i[dmem_addr_i] <= dmem_wdata_i;
  end

  mips32_pipe_fwd #(.XLEN(32), .AW(10), .RESET_PC(0), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_f), .imem_rdata(imem_rdata_f),
    .dmem_addr(dmem_addr_f), .dmem_wdata(dmem_wdata_f), .dmem_we(dmem_we_f),
    .dmem_rdata(dmem_rdata_f), .halted(halted_f), .illegal(illegal_f), .retire(retire_f),
    .dbg_raddr(dbg_f), .dbg_rdata(dbg_rdata_f));
  mips32_pipe_fwd #(.XLEN(32), .AW(10), .RESET_PC(0), .FWD_EN(0)) u_ilk (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_i), .imem_rdata(imem_rdata_i),
    .dmem_addr(dmem_addr_i), .dmem_wdata(dmem_wdata_i), .dmem_we(dmem_we_i),
    .dmem_rdata(dmem_rdata_i), .halted(halted_i), .illegal(illegal_i), .retire(retire_i),
    .dbg_raddr(dbg_i), .dbg_rdata(dbg_rdata_i));

  int errors = 0, checks = 0, cyc;
  int rq_f[$], rq_i[$];
  int we_cnt_f, we_cnt_i;
  logic [9:0]  we_addr_f, we_addr_i;
  logic [31:0] we_data_f, we_data_i, vf, vi;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [0:1023];
  int m_ret;
  bit m_ill;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, m;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    k  = $urandom_range(0, 40);
    m  = k % 13;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 15)) - 8);
    if (k == 40) return enc(BAD, rs, rt, imm);
    if (m < 6) return rr(6'(m), rs, rt, rd);
    if (m < 11) return enc(6'(m + 2), rs, rt, imm);
    return enc(6'(m + 2), rs, rt, 16'($urandom_range(1, 3)));
  endfunction

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic iss_run();
    logic [9:0] pc;
    logic [31:0] ir, a, b, imm;
    logic [4:0] d;
    logic [31:0] v;
    bit wr, done;
    int steps;
    for (int k = 0; k < 32; k++) m_reg[k] = 32'd0;
    for (int k = 0; k < 1024; k++) m_mem[k] = init_mem[k];
    pc = 10'd0; m_ret = 0; m_ill = 0; done = 0; steps = 0;
    while (!done && steps < 4000) begin
      ir = imem[pc];
      a = m_reg[ir[25:21]];
      b = m_reg[ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      wr = 1; d = ir[20:16]; v = 32'd0;
      m_ret++; steps++;
      pc = pc + 10'd1;
      case (ir[31:26])
        ADD:  begin d = ir[15:11]; v = a + b; end
        SUB:  begin d = ir[15:11]; v = a - b; end
        AND_: begin d = ir[15:11]; v = a & b; end
        OR_:  begin d = ir[15:11]; v = a | b; end
        SLT:  begin d = ir[15:11]; v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        MUL:  begin d = ir[15:11]; v = a * b; end
        ADDI: v = a + imm;
        SUBI: v = a - imm;
        SLTI: v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        LW:   v = m_mem[10'(a + imm)];
        SW:   begin wr = 0; m_mem[10'(a + imm)] = b; end
        BEQZ: begin wr = 0; if (a == 0) pc = pc + imm[9:0]; end
        BNEQZ: begin wr = 0; if (a != 0) pc = pc + imm[9:0]; end
        HLT:  begin wr = 0; done = 1; end
        default: begin wr = 0; done = 1; m_ill = 1; end
      endcase
      if (wr && d != 5'd0) m_reg[d] = v;
    end
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 1024; k++) begin
      imem[k] = {HLT, 26'd0};
      init_mem[k] = 32'd0;
    end
  endtask

  task automatic run_prog(input string name, input int max_cyc);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rq_f.delete(); rq_i.delete();
    we_cnt_f = 0; we_cnt_i = 0; cyc = 0;
    rst_n = 1'b1;
    while (!(halted_f && halted_i) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (retire_f) rq_f.push_back(cyc);
      if (retire_i) rq_i.push_back(cyc);
      if (dmem_we_f) begin we_cnt_f++; we_addr_f = dmem_addr_f; we_data_f = dmem_wdata_f; end
      if (dmem_we_i) begin we_cnt_i++; we_addr_i = dmem_addr_i; we_data_i = dmem_wdata_i; end
    end
    checks++;
    if (!(halted_f && halted_i)) begin
      errors++;
      $display("FAIL %s timeout: halted fwd=%0b ilk=%0b after %0d cycles, required both 1", name, halted_f, halted_i, cyc);
    end
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] of, output logic [31:0] oi);
    dbg_f = r; dbg_i = r;
    #1;
    of = dbg_rdata_f; oi = dbg_rdata_i;
  endtask

  task automatic test_reset();
    clear_prog();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({halted_f, illegal_f, retire_f, dmem_we_f} !== 4'b0) begin
      errors++; $display("FAIL reset_flags_fwd: got %b required 0000", {halted_f, illegal_f, retire_f, dmem_we_f});
    end
    checks++;
    if ({halted_i, illegal_i, retire_i, dmem_we_i} !== 4'b0) begin
      errors++; $display("FAIL reset_flags_ilk: got %b required 0000", {halted_i, illegal_i, retire_i, dmem_we_i});
    end
    checks++;
    if (imem_addr_f !== 10'd0 || imem_addr_i !== 10'd0) begin
      errors++; $display("FAIL reset_pc: got %0d/%0d required 0", imem_addr_f, imem_addr_i);
    end
    rd(5'd7, vf, vi);
    checks++;
    if (vf !== 32'd0 || vi !== 32'd0) begin
      errors++; $display("FAIL reset_reg7: got %0h/%0h required 0", vf, vi);
    end
  endtask

  task automatic test_fwd_basic();
    clear_prog();
    imem[0] = enc(ADDI, 0, 1, 16'd10);
    imem[1] = enc(ADDI, 0, 2, 16'd20);
    imem[2] = rr(ADD, 1, 2, 3);
    run_prog("fwd_basic", 200);
    rd(5'd3, vf, vi);
    checks++;
    if (vf !== 32'd30 || vi !== 32'd30) begin
      errors++; $display("FAIL fwd_basic_r3: got %0d/%0d required 30", vf, vi);
    end
    checks++;
    if (rq_f.size() != 4 || rq_f[0] != 4 || rq_f[3] - rq_f[0] != 3) begin
      errors++; $display("FAIL fwd_basic_retire: got n=%0d first=%0d last=%0d required n=4 first=4 last=7",
                         rq_f.size(), rq_f[0], rq_f[rq_f.size()-1]);
    end
    checks++;
    if (rq_i.size() != 4 || rq_i[2] - rq_i[1] != 3 || rq_i[3] - rq_i[2] != 1) begin
      errors++; $display("FAIL ilk_basic_bubbles: got n=%0d gap=%0d required n=4 gap=3", rq_i.size(), rq_i[2] - rq_i[1]);
    end
    checks++;
    if ({halted_f, illegal_f, halted_i, illegal_i} !== 4'b1010) begin
      errors++; $display("FAIL basic_halt: got %b required 1010", {halted_f, illegal_f, halted_i, illegal_i});
    end
  endtask

  task automatic test_load_use();
    clear_prog();
    init_mem[3] = 32'd7;
    imem[0] = enc(LW, 0, 4, 16'd3);
    imem[1] = rr(ADD, 4, 4, 5);
    imem[2] = enc(SLTI, 4, 6, 16'hFFFF);
    run_prog("load_use", 200);
    rd(5'd5, vf, vi);
    checks++;
    if (vf !== 32'd14 || vi !== 32'd14) begin
      errors++; $display("FAIL load_use_r5: got %0d/%0d required 14", vf, vi);
    end
    rd(5'd6, vf, vi);
    checks++;
    if (vf !== 32'd0 || vi !== 32'd0) begin
      errors++; $display("FAIL load_use_r6: got %0d/%0d required 0", vf, vi);
    end
    checks++;
    if (rq_f.size() != 4 || rq_f[1] - rq_f[0] != 2) begin
      errors++; $display("FAIL load_use_bubble: got gap=%0d required 2", rq_f[1] - rq_f[0]);
    end
    checks++;
    if (rq_i.size() != 4 || rq_i[1] - rq_i[0] != 3) begin
      errors++; $display("FAIL load_ilk_bubble: got gap=%0d required 3", rq_i[1] - rq_i[0]);
    end
  endtask

  task automatic test_store();
    clear_prog();
    imem[0] = enc(ADDI, 0, 1, 16'd10);
    imem[1] = enc(SW, 0, 1, 16'd5);
    imem[2] = enc(LW, 0, 7, 16'd5);
    run_prog("store", 200);
    checks++;
    if (we_cnt_f != 1 || we_addr_f !== 10'd5 || we_data_f !== 32'd10) begin
      errors++; $display("FAIL store_fwd: got n=%0d addr=%0d data=%0d required 1/5/10", we_cnt_f, we_addr_f, we_data_f);
    end
    checks++;
    if (we_cnt_i != 1 || we_addr_i !== 10'd5 || we_data_i !== 32'd10) begin
      errors++; $display("FAIL store_ilk: got n=%0d addr=%0d data=%0d required 1/5/10", we_cnt_i, we_addr_i, we_data_i);
    end
    rd(5'd7, vf, vi);
    checks++;
    if (vf !== 32'd10 || vi !== 32'd10) begin
      errors++; $display("FAIL store_r7: got %0d/%0d required 10", vf, vi);
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      logic [31:0] skip;
      clear_prog();
      imem[0] = enc((t == 1) ? BEQZ : BNEQZ, 0, 0, 16'd2);
      imem[1] = enc(ADDI, 0, 8, 16'd1);
      imem[2] = enc(ADDI, 0, 9, 16'd1);
      imem[3] = enc(ADDI, 0, 10, 16'd1);
      run_prog("branch", 200);
      skip = (t == 1) ? 32'd0 : 32'd1;
      for (int r = 8; r <= 10; r++) begin
        rd(5'(r), vf, vi);
        checks++;
        if (vf !== ((r == 10) ? 32'd1 : skip) || vi !== ((r == 10) ? 32'd1 : skip)) begin
          errors++; $display("FAIL branch_t%0d_r%0d: got %0d/%0d required %0d", t, r, vf, vi, (r == 10) ? 1 : skip);
        end
      end
      checks++;
      if (rq_f.size() < 2 || rq_f[1] - rq_f[0] != ((t == 1) ? 3 : 1)) begin
        errors++; $display("FAIL branch_t%0d_gap: got %0d required %0d", t, rq_f[1] - rq_f[0], (t == 1) ? 3 : 1);
      end
    end
  endtask

  task automatic test_illegal();
    logic [9:0] pc_hold;
    clear_prog();
    imem[0] = enc(ADDI, 0, 1, 16'd5);
    imem[1] = {BAD, 26'd0};
    imem[2] = enc(ADDI, 0, 2, 16'd7);
    run_prog("illegal", 200);
    checks++;
    if ({halted_f, illegal_f, halted_i, illegal_i} !== 4'b1111) begin
      errors++; $display("FAIL illegal_flags: got %b required 1111", {halted_f, illegal_f, halted_i, illegal_i});
    end
    rd(5'd1, vf, vi);
    checks++;
    if (vf !== 32'd5 || vi !== 32'd5) begin
      errors++; $display("FAIL illegal_r1: got %0d/%0d required 5", vf, vi);
    end
    rd(5'd2, vf, vi);
    checks++;
    if (vf !== 32'd0 || vi !== 32'd0) begin
      errors++; $display("FAIL illegal_r2: got %0d/%0d required 0", vf, vi);
    end
    checks++;
    if (rq_f.size() != 2 || rq_i.size() != 2) begin
      errors++; $display("FAIL illegal_retires: got %0d/%0d required 2", rq_f.size(), rq_i.size());
    end
    pc_hold = imem_addr_f;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (retire_f || retire_i || imem_addr_f !== pc_hold) begin
        errors++; $display("FAIL frozen: retire=%0b/%0b pc=%0d required 0/0 pc=%0d", retire_f, retire_i, imem_addr_f, pc_hold);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({halted_f, illegal_f, halted_i, illegal_i} !== 4'b0 || imem_addr_f !== 10'd0) begin
      errors++; $display("FAIL reset_clears: flags=%b pc=%0d required 0000 pc=0", {halted_f, illegal_f, halted_i, illegal_i}, imem_addr_f);
    end
    rd(5'd1, vf, vi);
    checks++;
    if (vf !== 32'd0 || vi !== 32'd0) begin
      errors++; $display("FAIL reset_clears_r1: got %0d/%0d required 0", vf, vi);
    end
    clear_prog();
    for (int k = 0; k < 12; k++) imem[k] = enc(ADDI, 5'(k % 7), 5'(k % 7 + 1), 16'(k + 3));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({retire_f, dmem_we_f, retire_i, dmem_we_i} !== 4'b0 || imem_addr_f !== 10'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %b pc=%0d required 0000 pc=0", {retire_f, dmem_we_f, retire_i, dmem_we_i}, imem_addr_f);
    end
    for (int r = 1; r < 8; r++) begin
      rd(5'(r), vf, vi);
      checks++;
      if (vf !== 32'd0 || vi !== 32'd0) begin
        errors++; $display("FAIL reset_mid_r%0d: got %0h/%0h required 0", r, vf, vi);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      int len, nd;
      clear_prog();
      len = $urandom_range(8, 24);
      for (int k = 0; k < len; k++) imem[k] = rand_instr();
      for (int k = 0; k < 1024; k++) init_mem[k] = $urandom;
      iss_run();
      run_prog("random", 1000);
      for (int r = 1; r < 32; r++) begin
        rd(5'(r), vf, vi);
        checks++;
        if (vf !== m_reg[r]) begin
          errors++; $display("FAIL rand%0d_fwd_r%0d: got %0h required %0h", t, r, vf, m_reg[r]);
        end
        checks++;
        if (vi !== m_reg[r]) begin
          errors++; $display("FAIL rand%0d_ilk_r%0d: got %0h required %0h", t, r, vi, m_reg[r]);
        end
      end
      checks++;
      if (rq_f.size() != m_ret || rq_i.size() != m_ret) begin
        errors++; $display("FAIL rand%0d_retires: got %0d/%0d required %0d", t, rq_f.size(), rq_i.size(), m_ret);
      end
      checks++;
      if (illegal_f !== m_ill || illegal_i !== m_ill) begin
        errors++; $display("FAIL rand%0d_illegal: got %0b/%0b required %0b", t, illegal_f, illegal_i, m_ill);
      end
      nd = 0;
      for (int k = 0; k < 1024; k++) if (dmem_f[k] !== m_mem[k] || dmem_i[k] !== m_mem[k]) nd++;
      checks++;
      if (nd != 0) begin
        errors++; $display("FAIL rand%0d_dmem: got %0d differing words required 0", t, nd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_load_use();
    test_store();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
